fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Byte-wide instruction fetch: pulls one- or two-byte instructions from
// program memory and hands them to decode over a valid/ready handshake.
module fetch_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   output logic [7:0] mem_addr,
   output logic       mem_rd,
   input  logic       mem_ack,
   input  logic [7:0] mem_data,
   output logic [7:0] ir_out,
   output logic [7:0] operand,
   output logic       ir_valid,
   input  logic       ir_ready,
   input  logic       br_taken,
   input  logic [7:0] br_target,
   output logic [7:0] pc_out
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FETCH_OP  = 2'd1,
      FETCH_ARG = 2'd2,
      ISSUE     = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [7:0] pc;
   logic [7:0] ir_q;
   logic [7:0] opnd_q;
   logic       two_byte;
   logic       take_op;
   logic       take_arg;

   assign two_byte = mem_data inside {8'hD0, 8'hD2, 8'hD4, 8'hD6};

   // a redirect in the same cycle swallows the returning byte
   assign take_op  = (state == FETCH_OP)  && mem_ack && !br_taken;
   assign take_arg = (state == FETCH_ARG) && mem_ack && !br_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (!br_taken && run) begin
               state_nx = FETCH_OP;
            end
         end
         FETCH_OP: begin
            if (br_taken) begin
               state_nx = FETCH_OP;
            end else if (mem_ack) begin
               state_nx = two_byte ? FETCH_ARG : ISSUE;
            end
         end
         FETCH_ARG: begin
            if (br_taken) begin
               state_nx = FETCH_OP;
            end else if (mem_ack) begin
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            if (br_taken) begin
               state_nx = FETCH_OP;
            end else if (ir_ready) begin
               state_nx = run ? FETCH_OP : IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      mem_rd   = 1'b0;
      ir_valid = 1'b0;
      unique case (state)
         IDLE:      ;
         FETCH_OP:  mem_rd   = 1'b1;
         FETCH_ARG: mem_rd   = 1'b1;
         ISSUE:     ir_valid = 1'b1;
         default:   ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= 8'h00;
         ir_q   <= 8'h00;
         opnd_q <= 8'h00;
      end else begin
         if (br_taken) begin
            pc <= br_target;
         end else if (take_op || take_arg) begin
            pc <= pc + 8'h01;
         end
         if (take_op) begin
            ir_q   <= mem_data;
            opnd_q <= 8'h00;
         end
         if (take_arg) begin
            opnd_q <= mem_data;
         end
      end
   end

   assign mem_addr = pc;
   assign pc_out   = pc;
   assign ir_out   = ir_q;
   assign operand  = opnd_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a program-walk model predicts the
// instruction stream, a monitor checks every accepted instruction.
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic       mem_ack = 1'b0;
   logic [7:0] mem_data = 8'h00;
   logic       ir_ready = 1'b0;
   logic       br_taken = 1'b0;
   logic [7:0] br_target = 8'h00;
   logic [7:0] mem_addr;
   logic       mem_rd;
   logic [7:0] ir_out;
   logic [7:0] operand;
   logic       ir_valid;
   logic [7:0] pc_out;

   typedef struct {
      logic [7:0] op;
      logic [7:0] arg;
      logic [7:0] pc;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       m_e;
   logic [7:0] mem[256];
   logic [7:0] twob[4] = '{8'hD0, 8'hD2, 8'hD4, 8'hD6};
   logic [7:0] mpc;
   int         total = 0;
   int         bad = 0;
   int         nhs = 0;
   int         lat_lo = 0;
   int         lat_hi = 0;
   int         cnt = 0;
   int         base;
   bit         spur = 1'b0;
   bit         ok;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_ack(mem_ack), .mem_data(mem_data),
      .ir_out(ir_out), .operand(operand),
      .ir_valid(ir_valid), .ir_ready(ir_ready),
      .br_taken(br_taken), .br_target(br_target),
      .pc_out(pc_out)
   );

   always #5 clk = ~clk;

   function automatic bit is2(input logic [7:0] b);
      return b inside {8'hD0, 8'hD2, 8'hD4, 8'hD6};
   endfunction

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %02h want %02h", nm, act, exp);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   // reference: walk program memory from the current model PC
   task automatic topup();
      exp_t e;
      while (exp_q.size() < 8) begin
         e.op = mem[mpc];
         mpc  = mpc + 8'h01;
         if (is2(e.op)) begin
            e.arg = mem[mpc];
            mpc   = mpc + 8'h01;
         end else begin
            e.arg = 8'h00;
         end
         e.pc = mpc;
         exp_q.push_back(e);
      end
   endtask

   task automatic restart(input logic [7:0] t);
      exp_q.delete();
      mpc = t;
      topup();
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
      topup();
   endtask

   task automatic br_go(input logic [7:0] t);
      br_target = t;
      br_taken  = 1'b1;
      cyc();
      br_taken  = 1'b0;
      restart(t);
   endtask

   task automatic do_reset();
      br_taken = 1'b0;
      rst_n    = 1'b0;
      #1;
      chkb("rst_mem_rd", mem_rd, 1'b0);
      chkb("rst_ir_valid", ir_valid, 1'b0);
      chk("rst_pc", pc_out, 8'h00);
      chk("rst_ir", ir_out, 8'h00);
      chk("rst_operand", operand, 8'h00);
      chk("rst_addr", mem_addr, 8'h00);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      restart(8'h00);
   endtask

   task automatic wait_hs(input int want, input int budget, input string nm);
      for (int i = 0; i < budget && nhs < want; i++) cyc();
      total++;
      if (nhs < want) begin
         bad++;
         $display("FAIL %s: handshakes %0d want %0d (timeout)", nm, nhs, want);
      end
   endtask

   task automatic wait_valid(input int budget, input string nm);
      for (int i = 0; i < budget && !ir_valid; i++) cyc();
      chkb(nm, ir_valid, 1'b1);
   endtask

   // program memory with programmable latency and stray acks
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         mem_ack = 1'b0;
         cnt     = $urandom_range(lat_hi, lat_lo);
      end else if (mem_rd) begin
         if (cnt == 0) begin
            mem_ack  = 1'b1;
            mem_data = mem[mem_addr];
            cnt      = $urandom_range(lat_hi, lat_lo);
         end else begin
            mem_ack  = 1'b0;
            mem_data = 8'($urandom);
            cnt--;
         end
      end else begin
         mem_ack  = spur && ($urandom_range(3, 0) == 0);
         mem_data = 8'($urandom);
         cnt      = $urandom_range(lat_hi, lat_lo);
      end
   end

   always @(negedge clk) begin
      if (rst_n && ir_valid) begin
         chkb("rd_during_issue", mem_rd, 1'b0);
         if (ir_ready) begin
            nhs++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_empty: got ir %02h want none", ir_out);
            end else begin
               m_e = exp_q.pop_front();
               chk("sb_ir", ir_out, m_e.op);
               chk("sb_operand", operand, m_e.arg);
               chk("sb_pc", pc_out, m_e.pc);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      @(posedge clk);
      #2;
      do_reset();

      // one-byte op acked at once
      mem[0] = 8'h50;
      do_reset();
      run = 1'b1;
      ir_ready = 1'b1;
      cyc();
      chkb("t1_rd", mem_rd, 1'b1);
      chk("t1_addr", mem_addr, 8'h00);
      cyc();
      chkb("t1_valid", ir_valid, 1'b1);
      chk("t1_ir", ir_out, 8'h50);
      chk("t1_operand", operand, 8'h00);
      cyc();
      chkb("t1_valid_drop", ir_valid, 1'b0);
      chk("t1_next_addr", mem_addr, 8'h01);
      run = 1'b0;

      // two-byte op with wait states
      mem[0] = 8'hD4;
      mem[1] = 8'h3C;
      lat_lo = 2;
      lat_hi = 2;
      ir_ready = 1'b0;
      do_reset();
      run = 1'b1;
      wait_valid(30, "t2_valid");
      chk("t2_ir", ir_out, 8'hD4);
      chk("t2_operand", operand, 8'h3C);
      chk("t2_pc", pc_out, 8'h02);
      base = nhs;
      ir_ready = 1'b1;
      run = 1'b0;
      wait_hs(base + 1, 10, "t2_hs");

      // stall in ISSUE, then single accept
      mem[0] = 8'h07;
      lat_lo = 0;
      lat_hi = 0;
      ir_ready = 1'b0;
      do_reset();
      run = 1'b1;
      wait_valid(10, "t3_valid");
      for (int i = 0; i < 5; i++) begin
         chkb("t3_hold_valid", ir_valid, 1'b1);
         chk("t3_hold_ir", ir_out, 8'h07);
         chk("t3_hold_operand", operand, 8'h00);
         chkb("t3_hold_rd", mem_rd, 1'b0);
         cyc();
      end
      base = nhs;
      ir_ready = 1'b1;
      run = 1'b0;
      cyc();
      ir_ready = 1'b0;
      chk("t3_one_accept", 8'(nhs - base), 8'd1);
      chkb("t3_valid_drop", ir_valid, 1'b0);
      cyc();
      cyc();
      chkb("t3_halt_rd", mem_rd, 1'b0);
      chk("t3_still_one", 8'(nhs - base), 8'd1);

      // redirect collides with opcode ack
      mem[0] = 8'hD0;
      do_reset();
      run = 1'b1;
      ir_ready = 1'b1;
      cyc();
      br_go(8'h80);
      chkb("t4_valid", ir_valid, 1'b0);
      chk("t4_addr", mem_addr, 8'h80);
      chk("t4_ir", ir_out, 8'h00);
      chkb("t4_rd", mem_rd, 1'b1);
      run = 1'b0;

      // PC wrap between opcode and operand
      mem[8'hFF] = 8'hD6;
      mem[0] = 8'h11;
      lat_hi = 1;
      do_reset();
      br_go(8'hFF);
      chk("t5_idle_pc", pc_out, 8'hFF);
      chkb("t5_idle_rd", mem_rd, 1'b0);
      base = nhs;
      run = 1'b1;
      wait_hs(base + 1, 40, "t5_hs");
      run = 1'b0;

      // one-byte op at FF, next fetch at 00
      mem[8'hFF] = 8'h33;
      do_reset();
      br_go(8'hFF);
      base = nhs;
      run = 1'b1;
      wait_hs(base + 1, 40, "t6_hs");
      chk("t6_wrap_addr", mem_addr, 8'h00);
      chkb("t6_wrap_rd", mem_rd, 1'b1);
      run = 1'b0;

      // async reset in the middle of operand fetch
      mem[0] = 8'hD2;
      lat_lo = 2;
      lat_hi = 2;
      do_reset();
      run = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         cyc();
         ok = mem_rd && (mem_addr == 8'h01);
      end
      chkb("t7_in_arg", ok, 1'b1);
      chk("t7_ir_before", ir_out, 8'hD2);
      rst_n = 1'b0;
      #1;
      chkb("t7_rd", mem_rd, 1'b0);
      chkb("t7_valid", ir_valid, 1'b0);
      chk("t7_ir", ir_out, 8'h00);
      chk("t7_pc", pc_out, 8'h00);
      run = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      restart(8'h00);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chkb("t7_no_rd", mem_rd, 1'b0);
      end

      // randomized traffic
      for (int i = 0; i < 256; i++) begin
         if ($urandom_range(9, 0) < 4) mem[i] = twob[$urandom_range(3, 0)];
         else mem[i] = 8'($urandom);
      end
      lat_lo = 0;
      lat_hi = 3;
      spur = 1'b1;
      do_reset();
      base = nhs;
      for (int i = 0; i < 3000; i++) begin
         int r;
         run = ($urandom_range(9, 0) != 0);
         ir_ready = ($urandom_range(9, 0) < 7);
         r = $urandom_range(199, 0);
         if (r < 8) br_go(8'($urandom));
         else if (r == 8) do_reset();
         else cyc();
      end
      total++;
      if (nhs - base < 200) begin
         bad++;
         $display("FAIL rand_progress: got %0d want >=200", nhs - base);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
